// File: rtl/mmio_fifo_pkg.sv
// ---------------------------------------------------------------------------
// mmio_fifo_pkg
//
// Shared definitions for the memory-mapped FIFO port: the register offsets
// inside the four-word window, the bit layout of the STATUS word and the
// command bits of the CTRL word, plus a helper that assembles STATUS.
// ---------------------------------------------------------------------------
package mmio_fifo_pkg;

    typedef enum logic [1:0] {
        OFS_TXDATA = 2'd0,
        OFS_RXDATA = 2'd1,
        OFS_STATUS = 2'd2,
        OFS_CTRL   = 2'd3
    } regOfs_e;

    localparam int STAT_RX_EMPTY     = 0;
    localparam int STAT_RX_FULL      = 1;
    localparam int STAT_TX_EMPTY     = 2;
    localparam int STAT_TX_FULL      = 3;
    localparam int STAT_TX_DROP      = 4;
    localparam int STAT_RX_COUNT_LSB = 6;
    localparam int STAT_TX_COUNT_LSB = 11;
    localparam int COUNT_FIELD_W     = 5;

    localparam int CTRL_POP_RX   = 0;
    localparam int CTRL_FLUSH_TX = 1;
    localparam int CTRL_FLUSH_RX = 2;
    localparam int CTRL_CLR_DROP = 3;

    // Builds the STATUS word; bit 5 is reserved and always reads as zero.
    function automatic logic [15:0] packStatus(
        input logic                     rxEmpty,
        input logic                     rxFull,
        input logic                     txEmpty,
        input logic                     txFull,
        input logic                     txDrop,
        input logic [COUNT_FIELD_W-1:0] rxCount,
        input logic [COUNT_FIELD_W-1:0] txCount
    );
        logic [15:0] status;
        status                                       = '0;
        status[STAT_RX_EMPTY]                        = rxEmpty;
        status[STAT_RX_FULL]                         = rxFull;
        status[STAT_TX_EMPTY]                        = txEmpty;
        status[STAT_TX_FULL]                         = txFull;
        status[STAT_TX_DROP]                         = txDrop;
        status[STAT_RX_COUNT_LSB +: COUNT_FIELD_W]   = rxCount;
        status[STAT_TX_COUNT_LSB +: COUNT_FIELD_W]   = txCount;
        return status;
    endfunction

endpackage

// File: rtl/mmio_fifo_port_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
//
// Single-clock word FIFO with a combinational head output, occupancy count
// and a synchronous flush. Pushes into a full FIFO and pops from an empty
// FIFO are ignored; a flush overrides any push or pop on the same edge.
//
// Ports:
//   clk_i    clock, rising edge
//   rst_ni   asynchronous active-low reset (pointers and count only)
//   push_i   write wdata_i at the tail
//   pop_i    drop the head entry
//   flush_i  empty the FIFO
//   wdata_i  word to push
//   rdata_o  current head word
//   empty_o  no entries held
//   full_o   DEPTH entries held
//   count_o  number of entries held
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int  WIDTH = 16,
    parameter int  DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [AW:0]      count_o
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q, wrPtr_d;
    logic [AW-1:0]    rdPtr_q, rdPtr_d;
    logic [AW:0]      count_q, count_d;
    logic             doPush;
    logic             doPop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_COUNT);
    assign count_o = count_q;
    assign rdata_o = mem_q[rdPtr_q];

    assign doPush = push_i && !full_o && !flush_i;
    assign doPop  = pop_i && !empty_o && !flush_i;

    // Pointer and occupancy update. DEPTH is a power of two, so the pointers
    // wrap on their own; a simultaneous push and pop leaves the count alone.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (flush_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (doPush) begin
                wrPtr_d = wrPtr_q + AW'(1);
            end
            if (doPop) begin
                rdPtr_d = rdPtr_q + AW'(1);
            end
            if (doPush && !doPop) begin
                count_d = count_q + (AW+1)'(1);
            end else if (!doPush && doPop) begin
                count_d = count_q - (AW+1)'(1);
            end
        end
    end

    // Pointer and count registers; the only FIFO state that is reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage array, deliberately left out of reset so it maps onto plain
    // registers or distributed RAM.
    always_ff @(posedge clk_i) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/mmio_fifo_port.sv
// ---------------------------------------------------------------------------
// mmio_fifo_port
//
// Memory-mapped responder on the processor data bus exposing a TX FIFO
// (filled by processor stores, drained by a valid/ready consumer) and an RX
// FIFO (filled by a valid/ready producer, read and popped by the processor).
// Read data is registered so it arrives with the same one-cycle latency as
// the synchronous RAM; Hit tells the top level to mux DIN from this block.
//
// Window (word addresses BASE..BASE+3):
//   +0 TXDATA  write pushes DOUT into TX
//   +1 RXDATA  read returns RX head (0 when empty), no side effect
//   +2 STATUS  read-only flags and counts
//   +3 CTRL    write: [0] pop RX, [1] flush TX, [2] flush RX, [3] clear drop
//
// Ports:
//   Clock, Resetn          clock and asynchronous active-low reset
//   ADDR, DOUT, W          processor word address, write data, write strobe
//   DIN, Hit               registered read data and window-hit flag
//   tx_data/valid/ready    TX consumer handshake
//   rx_data/valid/ready    RX producer handshake
// ---------------------------------------------------------------------------
module mmio_fifo_port
    import mmio_fifo_pkg::*;
#(
    parameter logic [15:0] BASE  = 16'h1000,
    parameter int          DEPTH = 8
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic [15:0] ADDR,
    input  logic [15:0] DOUT,
    input  logic        W,
    output logic [15:0] DIN,
    output logic        Hit,
    output logic [15:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [15:0] rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
);

    localparam int AW = $clog2(DEPTH);

    regOfs_e     regOfs;
    logic        match;
    logic        busWr;
    logic        ctrlWr;

    logic        txPush, txPop, txFlush;
    logic        rxPush, rxPop, rxFlush;
    logic        txEmpty, txFull;
    logic        rxEmpty, rxFull;
    logic [AW:0] txCount, rxCount;
    logic [15:0] rxHead;

    logic        dropSet, dropClr;
    logic        txDrop_q, txDrop_d;
    logic [15:0] rdData;
    logic [15:0] din_q, din_d;
    logic        hit_q, hit_d;
    logic        rxLive_q;

    assign match  = (ADDR[15:2] == BASE[15:2]);
    assign regOfs = regOfs_e'(ADDR[1:0]);
    assign busWr  = W && match;
    assign ctrlWr = busWr && (regOfs == OFS_CTRL);

    assign txPush  = busWr && (regOfs == OFS_TXDATA);
    assign txPop   = tx_valid && tx_ready;
    assign txFlush = ctrlWr && DOUT[CTRL_FLUSH_TX];

    assign rxPush  = rx_valid && rx_ready;
    assign rxPop   = ctrlWr && DOUT[CTRL_POP_RX];
    assign rxFlush = ctrlWr && DOUT[CTRL_FLUSH_RX];

    // A store that finds TX full is lost; fullness is the pre-edge view, so a
    // consumer pop on the same edge does not rescue it. A flush never drops.
    assign dropSet = txPush && txFull && !txFlush;
    assign dropClr = ctrlWr && DOUT[CTRL_CLR_DROP];

    assign tx_valid = !txEmpty;
    assign rx_ready = rxLive_q && !rxFull;
    assign DIN      = din_q;
    assign Hit      = hit_q;

    sync_fifo #(
        .WIDTH (16),
        .DEPTH (DEPTH)
    ) u_txFifo (
        .clk_i   (Clock),
        .rst_ni  (Resetn),
        .push_i  (txPush),
        .pop_i   (txPop),
        .flush_i (txFlush),
        .wdata_i (DOUT),
        .rdata_o (tx_data),
        .empty_o (txEmpty),
        .full_o  (txFull),
        .count_o (txCount)
    );

    sync_fifo #(
        .WIDTH (16),
        .DEPTH (DEPTH)
    ) u_rxFifo (
        .clk_i   (Clock),
        .rst_ni  (Resetn),
        .push_i  (rxPush),
        .pop_i   (rxPop),
        .flush_i (rxFlush),
        .wdata_i (rx_data),
        .rdata_o (rxHead),
        .empty_o (rxEmpty),
        .full_o  (rxFull),
        .count_o (rxCount)
    );

    // Sticky drop flag: a set on the same edge as a clear wins, so a lost
    // word is never hidden by a concurrent acknowledge.
    always_comb begin
        txDrop_d = txDrop_q;
        if (dropSet) begin
            txDrop_d = 1'b1;
        end else if (dropClr) begin
            txDrop_d = 1'b0;
        end
    end

    // Read mux. Reads are side-effect free because the bus has no read
    // strobe and ADDR may sit on this window for many cycles.
    always_comb begin
        rdData = '0;
        if (match) begin
            case (regOfs)
                OFS_RXDATA: rdData = rxEmpty ? 16'h0000 : rxHead;
                OFS_STATUS: rdData = packStatus(rxEmpty, rxFull, txEmpty, txFull, txDrop_q,
                                                COUNT_FIELD_W'(rxCount),
                                                COUNT_FIELD_W'(txCount));
                default:    rdData = '0;
            endcase
        end
        din_d = rdData;
        hit_d = match;
    end

    // Response registers and drop flag. rxLive_q keeps rx_ready low until the
    // first edge after reset is released.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            txDrop_q <= 1'b0;
            din_q    <= '0;
            hit_q    <= 1'b0;
            rxLive_q <= 1'b0;
        end else begin
            txDrop_q <= txDrop_d;
            din_q    <= din_d;
            hit_q    <= hit_d;
            rxLive_q <= 1'b1;
        end
    end

endmodule
